// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw push-button level and qualifies it.
// The debounced output follows a new level only after that level has been
// seen for STABLE_CYCLES consecutive clocks.
//
// Optional feature macro: DEBOUNCE_EDGE_EN adds one-clock rise/fall strobes.
//
// Ports:
//   clk   - single clock, rising edge
//   rst   - asynchronous, active-low reset
//   in    - raw, asynchronous, bouncing button level
//   out   - registered debounced level (feeds a downstream single_pulser)
//   rise  - (DEBOUNCE_EDGE_EN only) one-clock pulse when out goes 0->1
//   fall  - (DEBOUNCE_EDGE_EN only) one-clock pulse when out goes 1->0
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic                 ONE_CYCLE = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 s1;
  logic                 s2;
  logic                 go_high_c;
  logic                 go_low_c;

  // Two-flop synchronizer; only s2 is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  // Qualification complete this cycle; shared by the FSM, out and the strobes.
  always_comb begin
    go_high_c = 1'b0;
    go_low_c  = 1'b0;
    if (s2) begin
      go_high_c = ((state == LOW) && ONE_CYCLE) ||
                  ((state == RISE_CHK) && (cnt == CNT_LAST));
    end else begin
      go_low_c  = ((state == HIGH) && ONE_CYCLE) ||
                  ((state == FALL_CHK) && (cnt == CNT_LAST));
    end
  end

  // Stability FSM: any sample disagreeing with the candidate level restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOW;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      if (go_high_c) begin
        out <= 1'b1;
      end else if (go_low_c) begin
        out <= 1'b0;
      end
      case (state)
        LOW: begin
          if (s2 && ONE_CYCLE) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (s2) begin
            state <= RISE_CHK;
            cnt   <= CNT_WIDTH'(1);
          end else begin
            cnt   <= '0;
          end
        end
        RISE_CHK: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_WIDTH'(1);
          end
        end
        HIGH: begin
          if (!s2 && ONE_CYCLE) begin
            state <= LOW;
            cnt   <= '0;
          end else if (!s2) begin
            state <= FALL_CHK;
            cnt   <= CNT_WIDTH'(1);
          end else begin
            cnt   <= '0;
          end
        end
        FALL_CHK: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Strobes are registered alongside out so they coincide with its change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= go_high_c;
      fall <= go_low_c;
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: drives directed and randomized button activity into
// button_debouncer (STABLE_CYCLES=4) and compares every cycle against a
// run-length reference model, plus literal expectations for known scenarios.
module tb_button_debouncer;

  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic out;
`ifdef DEBOUNCE_EDGE_EN
  logic rise;
  logic fall;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: two-sample input delay, then a run of S samples that
  // disagree with the current debounced level flips it.
  logic m_s1, m_s2, m_out, m_rise, m_fall;
  int   m_run;

  always #5 clk = ~clk;

  button_debouncer #(
    .STABLE_CYCLES(S),
    .CNT_WIDTH    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise(rise),
    .fall(fall)
`endif
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!rst) begin
      m_s1  = 1'b0;
      m_s2  = 1'b0;
      m_out = 1'b0;
      m_run = 0;
    end else begin
      if (m_s2 != m_out) begin
        m_run++;
        if (m_run == int'(S)) begin
          m_out  = ~m_out;
          m_run  = 0;
          m_rise = m_out;
          m_fall = ~m_out;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = in;
    end
  endtask

  // One clock: drive the level, step the model at the edge, compare after it.
  task automatic tick(input logic v);
    in = v;
    @(posedge clk);
    model_edge();
    #1;
    check("model_out", out, m_out);
`ifdef DEBOUNCE_EDGE_EN
    check("model_rise", rise, m_rise);
    check("model_fall", fall, m_fall);
`endif
  endtask

  initial begin
    int   pulses;
    logic prev;
    logic pat [12];
    logic v;
    int   len;

    m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    m_run = 0;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Asynchronous reset is visible before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("reset_out", out, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
    check("reset_rise", rise, 1'b0);
    check("reset_fall", fall, 1'b0);
`endif
    repeat (3) tick(1'b0);
    rst = 1'b1;
    repeat (10) tick(1'b0);

    // Clean press: out rises at edge 5, rise strobes for that cycle only.
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      check("press_out", out, (i >= 5));
`ifdef DEBOUNCE_EDGE_EN
      check("press_rise", rise, (i == 5));
`endif
    end
    repeat (6) tick(1'b1);

    // Release: out falls at edge 5 with a single fall strobe.
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      check("release_out", out, (i < 5));
`ifdef DEBOUNCE_EDGE_EN
      check("release_fall", fall, (i == 5));
`endif
    end
    repeat (6) tick(1'b0);

    // Glitch of 3 clocks never qualifies.
    for (int i = 0; i < 13; i++) begin
      tick(i < 3);
      check("glitch_out", out, 1'b0);
`ifdef DEBOUNCE_EDGE_EN
      check("glitch_rise", rise, 1'b0);
`endif
    end

    // Bounce: qualification restarts at the final 0->1.
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      check("bounce_out", out, (i >= 5));
    end
    repeat (6) tick(1'b1);
    repeat (12) tick(1'b0);

    // Reset two clocks into qualification discards the partial count.
    repeat (4) tick(1'b1);
    rst = 1'b0;
    #1;
    check("midrst_out", out, 1'b0);
    check("midrst_cnt", (dut.cnt == '0), 1'b1);
    tick(1'b1);
    tick(1'b1);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      check("post_rst_out", out, (i >= 6));
    end
    repeat (12) tick(1'b0);

    // Bouncing press over 50 clocks gives exactly one debounced rise.
    pulses = 0;
    prev   = out;
    for (int i = 0; i < 50; i++) begin
      tick((i < 12) ? pat[i] : 1'b1);
      if (out && !prev) pulses++;
      prev = out;
    end
    check("chain_one_pulse", (pulses == 1), 1'b1);
    repeat (12) tick(1'b0);

    // Randomized runs of varied length, with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        #1;
        check("rand_rst_out", out, 1'b0);
        tick(v);
        rst = 1'b1;
      end
      repeat (len) tick(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 50000, SHALL set the number of consecutive clocks a synchronized level must hold before `out` follows it (legal range 1..2^CNT_WIDTH).
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the stability counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 in  input  1  SHALL be a raw, asynchronous, bouncing push-button level.
REQ-006 out  output  1  SHALL be the registered, debounced level, intended to drive the downstream single_pulser input.
REQ-007 rise  output  1  SHALL be present only under DEBOUNCE_EDGE_EN (see REQ-022).
REQ-008 fall  output  1  SHALL be present only under DEBOUNCE_EDGE_EN (see REQ-022).

Function
REQ-009 `in` SHALL pass through a two-flop synchronizer (s1, then s2); only s2 SHALL feed the FSM.
REQ-010 FSM states SHALL be LOW, RISE_CHK, HIGH and FALL_CHK; out SHALL be 1 in HIGH and FALL_CHK, and 0 otherwise, driven from a register.
REQ-011 LOW with s2=1: if STABLE_CYCLES=1, go to HIGH; otherwise go to RISE_CHK with cnt=1. LOW with s2=0: stay, cnt=0.
REQ-012 RISE_CHK with s2=0: return to LOW with cnt=0 (bounce restarts qualification).
REQ-013 RISE_CHK with s2=1 and cnt=STABLE_CYCLES-1: go to HIGH with cnt=0. RISE_CHK with s2=1 otherwise: cnt+1.
REQ-014 HIGH, FALL_CHK: SHALL mirror REQ-011..013 with polarities swapped, targeting LOW.
REQ-015 Latency: if `in` changes before edge k and then holds, out SHALL change at edge k+STABLE_CYCLES+1.
REQ-016 Any pulse of `in` that produces fewer than STABLE_CYCLES consecutive matching s2 samples SHALL leave out unchanged.
REQ-017 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 out SHALL change at most once per qualification; no state SHALL be reachable outside the four listed.

Reset
REQ-019 While rst=0, s1, s2, cnt, out, rise and fall SHALL be 0 and state SHALL be LOW, immediately and without waiting for a clock edge.
REQ-020 Reset asserted mid-qualification SHALL discard the partial count. After release, a held-high `in` SHALL raise out after STABLE_CYCLES+2 edges.
REQ-021 Reset deassertion SHALL take effect at the first rising clk edge with rst=1.

Configuration
REQ-022 With macro DEBOUNCE_EDGE_EN defined, registered outputs rise and fall SHALL each pulse high for exactly one clock, in the same cycle that out goes 0->1 or 1->0 respectively.
REQ-023 Without DEBOUNCE_EDGE_EN, the rise and fall ports and their logic SHALL NOT exist, and out behaviour SHALL be identical to the macro-defined build.

Verification (STABLE_CYCLES=4, 10 ns clock)
REQ-024 Clean press: in 0->1 before edge 0 and held -> out=1 from edge 5; with the macro, rise=1 for exactly the cycle after edge 5.
REQ-025 Glitch: in high for 3 clocks, then low -> out stays 0 throughout; rise never asserts.
REQ-026 Bounce: in high 2 clocks, low 1 clock, then high held -> out rises 5 edges after the final 0->1, not earlier.
REQ-027 Release: from out=1, in 1->0 held -> out=0 at edge+5; with the macro, fall=1 for one cycle.
REQ-028 Reset mid-count: pull rst low 2 clocks into RISE_CHK -> out=0 and cnt=0 immediately; with in held high, out=1 after 6 edges past release.
REQ-029 Chain check: out feeds single_pulser; a 50-clock bouncing press -> exactly one single_pulser output pulse.
